// File: rtl/vending_fsm_multi.sv
// Multi-item vending controller: accumulates coin credit, vends a selected
// item once credit covers its price, returns change and refunds on cancel or
// idle timeout. Dispenser and change hopper use valid/ready handshakes, and
// every output comes straight from a flop.
module vending_fsm_multi #(
    parameter int                            CREDIT_W    = 4,
    parameter int                            NUM_ITEMS   = 4,
    parameter logic [NUM_ITEMS*CREDIT_W-1:0] PRICES      = {4'd4, 4'd3, 4'd2, 4'd1},
    parameter int                            TIMEOUT_CYC = 255,
    localparam int                           IW          = (NUM_ITEMS > 1) ? $clog2(NUM_ITEMS) : 1
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                coin_valid,
    input  logic [CREDIT_W-1:0] coin_value,
    input  logic                sel_valid,
    input  logic [IW-1:0]       sel_item,
    input  logic                cancel,
    input  logic                disp_ready,
    input  logic                change_ready,
    output logic                disp_valid,
    output logic [IW-1:0]       disp_item,
    output logic                change_valid,
    output logic [CREDIT_W-1:0] change_amount,
    output logic                coin_reject,
    output logic                sel_denied,
    output logic [CREDIT_W-1:0] credit,
    output logic                busy
);

    localparam int TW = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;

    typedef enum logic [1:0] {S_IDLE, S_CREDIT, S_VEND, S_CHANGE} state_t;

    state_t              r_state;
    logic [CREDIT_W-1:0] r_credit;
    logic [TW-1:0]       r_timer;
    logic [IW-1:0]       r_item;

    state_t              w_state_nxt;
    logic [CREDIT_W-1:0] w_credit_nxt;
    logic [TW-1:0]       w_timer_nxt;
    logic [IW-1:0]       w_item_nxt;
    logic                w_reject_nxt;
    logic                w_denied_nxt;

    logic                w_disp_valid_nxt;
    logic [IW-1:0]       w_disp_item_nxt;
    logic                w_change_valid_nxt;
    logic [CREDIT_W-1:0] w_change_amount_nxt;
    logic                w_busy_nxt;

    // Price table lookup; indices past the last item read as zero.
    function automatic logic [CREDIT_W-1:0] price_of(input logic [IW-1:0] idx);
        logic [CREDIT_W-1:0] p;
        p = '0;
        for (int i = 0; i < NUM_ITEMS; i++) begin
            if (int'(idx) == i) p = PRICES[i*CREDIT_W +: CREDIT_W];
        end
        return p;
    endfunction

    // A coin of value zero is no event at all; cancel or a selection in the
    // same cycle always outranks a coin, whatever the state.
    logic                w_coin;
    logic                w_coin_blocked;
    logic [CREDIT_W:0]   w_sum;
    logic                w_coin_ovf;
    logic                w_sel_ok;
    logic [CREDIT_W-1:0] w_vend_price;
    logic                w_timeout;

    assign w_coin         = coin_valid && (coin_value != '0);
    assign w_coin_blocked = cancel || sel_valid;
    assign w_sum          = {1'b0, r_credit} + {1'b0, coin_value};
    assign w_coin_ovf     = w_sum[CREDIT_W];
    assign w_sel_ok       = (int'(sel_item) < NUM_ITEMS) && (r_credit >= price_of(sel_item));
    assign w_vend_price   = price_of(r_item);
    assign w_timeout      = (TIMEOUT_CYC != 0) && (int'(r_timer) == TIMEOUT_CYC - 1);

    // State register plus registered copies of every output.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state       <= S_IDLE;
            r_credit      <= '0;
            r_timer       <= '0;
            r_item        <= '0;
            disp_valid    <= 1'b0;
            disp_item     <= '0;
            change_valid  <= 1'b0;
            change_amount <= '0;
            coin_reject   <= 1'b0;
            sel_denied    <= 1'b0;
            credit        <= '0;
            busy          <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            r_state       <= w_state_nxt;
            r_credit      <= w_credit_nxt;
            r_timer       <= w_timer_nxt;
            r_item        <= w_item_nxt;
            disp_valid    <= w_disp_valid_nxt;
            disp_item     <= w_disp_item_nxt;
            change_valid  <= w_change_valid_nxt;
            change_amount <= w_change_amount_nxt;
            coin_reject   <= w_reject_nxt;
            sel_denied    <= w_denied_nxt;
            credit        <= w_credit_nxt;
            busy          <= w_busy_nxt;
        end
    end

    // Next state, credit, timer and the reject/deny pulses.
    always_comb begin
        // NOTE: defaults first so no path through the case can infer a latch.
        w_state_nxt  = r_state;
        w_credit_nxt = r_credit;
        w_timer_nxt  = r_timer;
        w_item_nxt   = r_item;
        w_reject_nxt = 1'b0;
        w_denied_nxt = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_denied_nxt = sel_valid;
                if (w_coin) begin
                    if (w_coin_blocked || w_coin_ovf) begin
                        w_reject_nxt = 1'b1;
                    end else begin
                        w_credit_nxt = w_sum[CREDIT_W-1:0];
                        w_timer_nxt  = '0;
                        w_state_nxt  = S_CREDIT;
                    end
                end
            end
            S_CREDIT: begin
                if (cancel) begin
                    w_state_nxt  = S_CHANGE;
                    w_denied_nxt = sel_valid;
                    w_reject_nxt = w_coin;
                end else if (sel_valid) begin
                    w_reject_nxt = w_coin;
                    if (w_sel_ok) begin
                        w_item_nxt  = sel_item;
                        w_state_nxt = S_VEND;
                    end else begin
                        w_denied_nxt = 1'b1;
                        w_timer_nxt  = '0;
                    end
                end else if (w_coin && !w_coin_ovf) begin
                    w_credit_nxt = w_sum[CREDIT_W-1:0];
                    w_timer_nxt  = '0;
                end else begin
                    w_reject_nxt = w_coin;
                    if (w_timeout) begin
                        w_state_nxt = S_CHANGE;
                    end else begin
                        w_timer_nxt = r_timer + TW'(1);
                    end
                end
            end
            S_VEND: begin
                w_denied_nxt = sel_valid;
                w_reject_nxt = w_coin;
                if (disp_ready) begin
                    w_credit_nxt = r_credit - w_vend_price;
                    w_state_nxt  = (r_credit == w_vend_price) ? S_IDLE : S_CHANGE;
                end
            end
            S_CHANGE: begin
                w_denied_nxt = sel_valid;
                w_reject_nxt = w_coin;
                if (change_ready) begin
                    w_credit_nxt = '0;
                    w_state_nxt  = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Output values decoded from the next state so they register alongside it.
    always_comb begin
        w_disp_valid_nxt    = (w_state_nxt == S_VEND);
        w_change_valid_nxt  = (w_state_nxt == S_CHANGE);
        w_disp_item_nxt     = w_disp_valid_nxt ? w_item_nxt : '0;
        w_change_amount_nxt = w_change_valid_nxt ? w_credit_nxt : '0;
        w_busy_nxt          = w_disp_valid_nxt || w_change_valid_nxt;
    end

endmodule

// File: tb/tb_vending_fsm_multi.sv
// Bench for vending_fsm_multi: two instances share stimulus (default 4 items
// with a 255-cycle timeout, and 3 items with an 8-cycle timeout). Directed
// scenarios run first, then randomized traffic checked against a
// transaction-level model of the vending rules.
module tb_vending_fsm_multi;

    localparam int M_IDLE   = 0;
    localparam int M_CREDIT = 1;
    localparam int M_VEND   = 2;
    localparam int M_CHANGE = 3;
    localparam int MAX_CRED = 15;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       coin_valid = 1'b0;
    logic [3:0] coin_value = '0;
    logic       sel_valid = 1'b0;
    logic [1:0] sel_item = '0;
    logic       cancel = 1'b0;
    logic       disp_ready = 1'b0;
    logic       change_ready = 1'b0;

    logic       dv[2], cv[2], rej[2], den[2], bsy[2];
    logic [1:0] ditem[2];
    logic [3:0] camt[2], cr[2];

    int n_total = 0;
    int n_bad   = 0;

    int n_items[2]   = '{4, 3};
    int tmo[2]       = '{255, 8};
    int price_tab[4] = '{1, 2, 3, 4};

    typedef struct {
        int st;
        int credit;
        int timer;
        int item;
        bit rej;
        bit den;
    } mdl_t;
    mdl_t m[2];

    always #5 clk = ~clk;

    vending_fsm_multi u_d0 (
        .clk(clk), .reset_n(reset_n),
        .coin_valid(coin_valid), .coin_value(coin_value),
        .sel_valid(sel_valid), .sel_item(sel_item), .cancel(cancel),
        .disp_ready(disp_ready), .change_ready(change_ready),
        .disp_valid(dv[0]), .disp_item(ditem[0]),
        .change_valid(cv[0]), .change_amount(camt[0]),
        .coin_reject(rej[0]), .sel_denied(den[0]),
        .credit(cr[0]), .busy(bsy[0])
    );

    vending_fsm_multi #(
        .CREDIT_W(4), .NUM_ITEMS(3), .PRICES(12'h321), .TIMEOUT_CYC(8)
    ) u_d1 (
        .clk(clk), .reset_n(reset_n),
        .coin_valid(coin_valid), .coin_value(coin_value),
        .sel_valid(sel_valid), .sel_item(sel_item), .cancel(cancel),
        .disp_ready(disp_ready), .change_ready(change_ready),
        .disp_valid(dv[1]), .disp_item(ditem[1]),
        .change_valid(cv[1]), .change_amount(camt[1]),
        .coin_reject(rej[1]), .sel_denied(den[1]),
        .credit(cr[1]), .busy(bsy[1])
    );

    task automatic check(input string tag, input int got, input int exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Apply one clock edge of the vending rules to model k.
    task automatic step(input int k);
        int  v;
        bit  coin_ev;
        bit  blocked;
        v       = int'(coin_value);
        coin_ev = coin_valid && (v != 0);
        blocked = cancel || sel_valid;
        m[k].rej = 1'b0;
        m[k].den = 1'b0;
        case (m[k].st)
            M_IDLE: begin
                m[k].den = sel_valid;
                if (coin_ev) begin
                    if (blocked || v > MAX_CRED) m[k].rej = 1'b1;
                    else begin
                        m[k].credit = v;
                        m[k].timer  = 0;
                        m[k].st     = M_CREDIT;
                    end
                end
            end
            M_CREDIT: begin
                if (cancel) begin
                    m[k].st  = M_CHANGE;
                    m[k].den = sel_valid;
                    m[k].rej = coin_ev;
                end else if (sel_valid) begin
                    m[k].rej = coin_ev;
                    if (int'(sel_item) < n_items[k] && m[k].credit >= price_tab[sel_item]) begin
                        m[k].item = int'(sel_item);
                        m[k].st   = M_VEND;
                    end else begin
                        m[k].den   = 1'b1;
                        m[k].timer = 0;
                    end
                end else if (coin_ev && m[k].credit + v <= MAX_CRED) begin
                    m[k].credit += v;
                    m[k].timer  = 0;
                end else begin
                    m[k].rej = coin_ev;
                    if (tmo[k] != 0 && m[k].timer + 1 == tmo[k]) m[k].st = M_CHANGE;
                    else m[k].timer++;
                end
            end
            M_VEND: begin
                m[k].den = sel_valid;
                m[k].rej = coin_ev;
                if (disp_ready) begin
                    m[k].credit -= price_tab[m[k].item];
                    m[k].st = (m[k].credit == 0) ? M_IDLE : M_CHANGE;
                end
            end
            default: begin
                m[k].den = sel_valid;
                m[k].rej = coin_ev;
                if (change_ready) begin
                    m[k].credit = 0;
                    m[k].st     = M_IDLE;
                end
            end
        endcase
    endtask

    task automatic check_all(input int k);
        bit in_vend, in_chg;
        in_vend = (m[k].st == M_VEND);
        in_chg  = (m[k].st == M_CHANGE);
        check($sformatf("d%0d.disp_valid", k), int'(dv[k]), int'(in_vend));
        check($sformatf("d%0d.disp_item", k), int'(ditem[k]), in_vend ? m[k].item : 0);
        check($sformatf("d%0d.change_valid", k), int'(cv[k]), int'(in_chg));
        check($sformatf("d%0d.change_amount", k), int'(camt[k]), in_chg ? m[k].credit : 0);
        check($sformatf("d%0d.coin_reject", k), int'(rej[k]), int'(m[k].rej));
        check($sformatf("d%0d.sel_denied", k), int'(den[k]), int'(m[k].den));
        check($sformatf("d%0d.credit", k), int'(cr[k]), m[k].credit);
        check($sformatf("d%0d.busy", k), int'(bsy[k]), int'(in_vend || in_chg));
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m[k].st = M_IDLE; m[k].credit = 0; m[k].timer = 0;
            m[k].item = 0; m[k].rej = 1'b0; m[k].den = 1'b0;
        end
    endtask

    // Drop reset a little after an edge: outputs must clear without a clock.
    task automatic do_reset();
        reset_n = 1'b0;
        #1;
        model_reset();
        for (int k = 0; k < 2; k++) begin
            check($sformatf("d%0d.rst_outputs", k),
                  int'({dv[k], ditem[k], cv[k], camt[k], rej[k], den[k], cr[k], bsy[k]}), 0);
        end
        @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    // One clock: present inputs, let the edge pass, update models, compare.
    task automatic cycle(input bit c_v, input int c_val, input bit s_v, input int s_i,
                         input bit cn, input bit dr, input bit chr);
        int tmp_val;
        int tmp_item;
        tmp_val      = c_val;
        tmp_item     = s_i;
        coin_valid   = c_v;
        coin_value   = tmp_val[3:0];
        sel_valid    = s_v;
        sel_item     = tmp_item[1:0];
        cancel       = cn;
        disp_ready   = dr;
        change_ready = chr;
        @(posedge clk);
        step(0);
        step(1);
        #1;
        check_all(0);
        check_all(1);
        coin_valid = 1'b0;
        sel_valid  = 1'b0;
        cancel     = 1'b0;
    endtask

    task automatic idle(input int n, input bit dr, input bit chr);
        for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, 0, dr, chr);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        @(posedge clk);
        do_reset();

        // Scenario 1: 2+2 credit, item2 at price 3, change of 1.
        cycle(1, 2, 0, 0, 0, 1, 1);
        cycle(1, 2, 0, 0, 0, 1, 1);
        cycle(0, 0, 1, 2, 0, 1, 1);
        check("t1.disp_valid", int'(dv[0]), 1);
        check("t1.disp_item", int'(ditem[0]), 2);
        cycle(0, 0, 0, 0, 0, 1, 1);
        check("t1.change_amount", int'(camt[0]), 1);
        cycle(0, 0, 0, 0, 0, 1, 1);
        check("t1.credit_after", int'(cr[0]), 0);

        // Scenario 2: exact price, no change.
        cycle(1, 1, 0, 0, 0, 1, 1);
        cycle(0, 0, 1, 0, 0, 1, 1);
        cycle(0, 0, 0, 0, 0, 1, 1);
        check("t2.no_change", int'(cv[0]), 0);
        check("t2.idle_busy", int'(bsy[0]), 0);

        // Scenario 3: overflowing coin rejected, then full refund of 14.
        cycle(1, 7, 0, 0, 0, 0, 0);
        cycle(1, 7, 0, 0, 0, 0, 0);
        cycle(1, 5, 0, 0, 0, 0, 0);
        check("t3.coin_reject", int'(rej[0]), 1);
        check("t3.credit_kept", int'(cr[0]), 14);
        cycle(0, 0, 0, 0, 1, 0, 0);
        check("t3.refund", int'(camt[0]), 14);
        idle(2, 0, 0);
        idle(1, 0, 1);

        // Scenario 4: unaffordable / nonexistent item, then coin+sel+cancel.
        cycle(1, 2, 0, 0, 0, 0, 0);
        cycle(0, 0, 1, 3, 0, 0, 0);
        check("t4.denied_price", int'(den[0]), 1);
        check("t4.denied_range", int'(den[1]), 1);
        cycle(1, 3, 1, 0, 1, 0, 0);
        check("t4.refund_amount", int'(camt[0]), 2);
        check("t4.coin_lost", int'(rej[0]), 1);
        idle(1, 0, 1);

        // Scenario 5: stalled dispenser, ignored cancel, reset mid-vend.
        cycle(1, 4, 0, 0, 0, 0, 0);
        cycle(0, 0, 1, 3, 0, 0, 0);
        for (int i = 0; i < 10; i++) begin
            cycle(i == 3, 2, 0, 0, i == 6, 0, 0);
            check("t5.disp_hold", int'({dv[0], ditem[0]}), 7);
        end
        do_reset();

        // Scenario 6: short timeout refunds 3 after eight idle cycles.
        cycle(1, 3, 0, 0, 0, 0, 0);
        for (int i = 1; i <= 8; i++) begin
            idle(1, 0, 0);
            check("t6.timeout", int'(cv[1]), int'(i == 8));
        end
        check("t6.amount", int'(camt[1]), 3);
        idle(1, 0, 1);

        // Randomized traffic with occasional resets.
        for (int n = 0; n < 4000; n++) begin
            if ($urandom_range(399) == 0) begin
                do_reset();
            end else begin
                cycle($urandom_range(2) == 0, int'($urandom_range(9)),
                      $urandom_range(5) == 0, int'($urandom_range(3)),
                      $urandom_range(24) == 0,
                      $urandom_range(1) == 1, $urandom_range(2) != 0);
            end
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
